chroma_modulator: RTL and testbench

- Produces the modulated chroma component of the composite signal: free-running subcarrier phase accumulator, sine/cosine lookup, U/V quadrature modulation, colour-burst insertion and PAL V-switch.
- Sits beside the luma path and feeds the composite summer.
- Has a fixed, exported pipeline latency. The luma delay line is programmed with latency = CHROMA_LATENCY-1, because the delay line adds one output register. Luma and chroma then arrive aligned.

---
 rtl/video_pkg.sv | 43 ++++
 rtl/sine_lut.sv | 45 ++++
 rtl/chroma_modulator.sv | 124 ++++++++++++
 tb/tb_chroma_modulator.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video constants and helpers for the composite encoder.
package video_pkg;

  // Pipeline depth of the chroma path; the luma delay line is set to this minus one.
  localparam int CHROMA_LATENCY = 3;

  localparam int PHASE_BITS_DEF = 32;
  localparam int LUT_BITS_DEF   = 8;
  localparam int DATA_BITS_DEF  = 8;

  // Sine table amplitude and storage width; the MAC shift undoes the x127 scaling.
  localparam int LUT_AMP      = 127;
  localparam int LUT_AMP_BITS = 8;
  localparam int MAC_SHIFT    = 7;

  // cos(45deg) * 256, used to split the PAL burst between -U and +V.
  localparam int PAL_BURST_SCALE = 181;

  // Subcarrier frequency words for a 27 MHz clock (3.579545 MHz / 4.43361875 MHz).
  localparam logic [31:0] NTSC_PHASE_INC = 32'h21F0_7C1F;
  localparam logic [31:0] PAL_PHASE_INC  = 32'h2A09_8ACB;

  localparam real PI = 3.14159265358979323846;

  // Clamp x to the signed range of a bits-wide word.
  function automatic int sat_signed(input int x, input int bits);
    int hi;
    int lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // One entry of a full-period sine table, rounded half away from zero.
  function automatic int sine_entry(input int i, input int depth);
    real y;
    y = real'(LUT_AMP) * $sin(2.0 * PI * real'(i) / real'(depth));
    return (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(0.5 - y);
  endfunction

endpackage

// File: rtl/sine_lut.sv
// Full-period signed sine ROM with two registered read ports (sine and cosine).
module sine_lut
  import video_pkg::*;
#(
  parameter int LUT_BITS = LUT_BITS_DEF,
  parameter int AMP_BITS = LUT_AMP_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LUT_BITS-1:0]        idx,
  output logic signed [AMP_BITS-1:0] sin_q,
  output logic signed [AMP_BITS-1:0] cos_q
);

  localparam int DEPTH   = 1 << LUT_BITS;
  localparam int QUARTER = DEPTH / 4;

  logic signed [AMP_BITS-1:0] rom [DEPTH];
  logic [LUT_BITS-1:0]        cos_idx;
  logic signed [AMP_BITS-1:0] sin_d;
  logic signed [AMP_BITS-1:0] cos_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom[gi] = AMP_BITS'(sine_entry(gi, DEPTH));
  end

  // Cosine is the sine a quarter turn ahead; the index wraps naturally.
  always_comb begin
    cos_idx = idx + LUT_BITS'(QUARTER);
    sin_d   = rom[idx];
    cos_d   = rom[cos_idx];
  end

  // Registered read on both ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_q <= '0;
      cos_q <= '0;
    end else begin
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end

endmodule

// File: rtl/chroma_modulator.sv
// Subcarrier NCO, U/V operand select with burst and PAL V-switch, and quadrature MAC.
module chroma_modulator
  import video_pkg::*;
#(
  parameter int PHASE_BITS = PHASE_BITS_DEF,
  parameter int LUT_BITS   = LUT_BITS_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PHASE_BITS-1:0]       phase_inc,
  input  logic                        phase_clear,
  input  logic                        pal_mode,
  input  logic                        line_start,
  input  logic                        burst_en,
  input  logic                        active,
  input  logic signed [DATA_BITS-1:0] u,
  input  logic signed [DATA_BITS-1:0] v,
  input  logic [DATA_BITS-1:0]        burst_amp,
  output logic signed [DATA_BITS:0]   chroma_out,
  output logic                        vsw
);

  // Operands carry one extra bit: an NTSC burst can reach -(2^DATA_BITS - 1).
  localparam int OPW  = DATA_BITS + 1;
  localparam int OUTW = DATA_BITS + 1;
  localparam int SUMW = OPW + LUT_AMP_BITS + 1;

  localparam logic [DATA_BITS+7:0]  PAL_SCALE_W = (DATA_BITS + 8)'(PAL_BURST_SCALE);
  localparam logic signed [OPW-1:0] V_MIN = OPW'(-(1 << (DATA_BITS - 1)));
  localparam logic signed [OPW-1:0] V_MAX = OPW'((1 << (DATA_BITS - 1)) - 1);

  logic [PHASE_BITS-1:0]         acc_q, acc_d;
  logic                          vsw_q, vsw_d;
  logic [LUT_BITS-1:0]           idx_q, idx_d;
  logic signed [OPW-1:0]         up_q, up_d, vp_q, vp_d;
  logic signed [OPW-1:0]         up2_q, vp2_q;
  logic signed [OUTW-1:0]        chroma_q, chroma_d;
  logic signed [LUT_AMP_BITS-1:0] sin_w, cos_w;

  logic [DATA_BITS+7:0]          burst_prod;
  logic signed [OPW-1:0]         burst_k, burst_full, u_sel, v_sel;
  logic signed [SUMW-1:0]        u_ext, v_ext, s_ext, c_ext, sum, shifted;

  // Phase accumulator and V-switch next state; a new line_start toggle applies to this sample.
  always_comb begin
    acc_d = phase_clear ? '0 : acc_q + phase_inc;
    vsw_d = pal_mode & (vsw_q ^ line_start);
    idx_d = acc_q[PHASE_BITS-1 -: LUT_BITS];
  end

  // Stage 1 operand select: burst beats active video beats blanking, then V-switch.
  always_comb begin
    burst_prod = burst_amp * PAL_SCALE_W;
    burst_k    = {1'b0, DATA_BITS'(burst_prod >> 8)};
    burst_full = {1'b0, burst_amp};
    u_sel      = '0;
    v_sel      = '0;
    if (burst_en) begin
      if (pal_mode) begin
        u_sel = -burst_k;
        v_sel = burst_k;
      end else begin
        u_sel = -burst_full;
      end
    end else if (active) begin
      u_sel = {u[DATA_BITS-1], u};
      v_sel = {v[DATA_BITS-1], v};
    end
    up_d = u_sel;
    // The most negative sample value has no positive twin; clip it to full scale.
    if (vsw_d) vp_d = (v_sel == V_MIN) ? V_MAX : -v_sel;
    else       vp_d = v_sel;
  end

  // Stage 3 MAC: full-width quadrature sum, remove table scaling, clip to output range.
  always_comb begin
    u_ext    = $signed({{(SUMW-OPW){up2_q[OPW-1]}}, up2_q});
    v_ext    = $signed({{(SUMW-OPW){vp2_q[OPW-1]}}, vp2_q});
    s_ext    = $signed({{(SUMW-LUT_AMP_BITS){sin_w[LUT_AMP_BITS-1]}}, sin_w});
    c_ext    = $signed({{(SUMW-LUT_AMP_BITS){cos_w[LUT_AMP_BITS-1]}}, cos_w});
    sum      = u_ext * s_ext + v_ext * c_ext;
    shifted  = sum >>> MAC_SHIFT;
    chroma_d = OUTW'(sat_signed(int'(shifted), OUTW));
  end

  // All state: accumulator, V-switch, and the three pipeline stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      vsw_q    <= 1'b0;
      idx_q    <= '0;
      up_q     <= '0;
      vp_q     <= '0;
      up2_q    <= '0;
      vp2_q    <= '0;
      chroma_q <= '0;
    end else begin
      acc_q    <= acc_d;
      vsw_q    <= vsw_d;
      idx_q    <= idx_d;
      up_q     <= up_d;
      vp_q     <= vp_d;
      up2_q    <= up_q;
      vp2_q    <= vp_q;
      chroma_q <= chroma_d;
    end
  end

  sine_lut #(
    .LUT_BITS (LUT_BITS),
    .AMP_BITS (LUT_AMP_BITS)
  ) u_sine_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (idx_q),
    .sin_q (sin_w),
    .cos_q (cos_w)
  );

  assign chroma_out = chroma_q;
  assign vsw        = vsw_q;

endmodule

// File: tb/tb_chroma_modulator.sv
// Self-checking bench for chroma_modulator: directed table, corner sequences, random vs model.
module tb_chroma_modulator;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       phase_inc;
  logic              phase_clear, pal_mode, line_start, burst_en, active;
  logic signed [7:0] u, v;
  logic [7:0]        burst_amp;
  logic signed [8:0] chroma_out;
  logic              vsw;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chroma_modulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .phase_inc   (phase_inc),
    .phase_clear (phase_clear),
    .pal_mode    (pal_mode),
    .line_start  (line_start),
    .burst_en    (burst_en),
    .active      (active),
    .u           (u),
    .v           (v),
    .burst_amp   (burst_amp),
    .chroma_out  (chroma_out),
    .vsw         (vsw)
  );

  typedef struct {
    int idx; bit pal; bit ls; bit burst; bit act;
    int uu; int vv; int amp; int exp_c;
  } vec_t;

  vec_t vecs[17];
  int   exp_q[$];

  task automatic check(input string name, input int act_v, input int exp_v);
    n_cmp++;
    if (act_v != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    phase_inc = '0; phase_clear = 0; pal_mode = 0; line_start = 0;
    burst_en = 0; active = 0; u = '0; v = '0; burst_amp = '0;
  endtask

  // Park the accumulator at idx<<24 and the V-switch at 0.
  task automatic set_phase(input int idx);
    pal_mode = 0; line_start = 0; phase_clear = 1; phase_inc = '0;
    step();
    phase_clear = 0; phase_inc = 32'(idx) << 24;
    step();
    phase_inc = '0;
  endtask

  function automatic int rnd(input real y);
    return (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(0.5 - y);
  endfunction

  // Reference: chroma = U*sin(theta) + V*cos(theta) with a 127-amplitude carrier.
  function automatic int model_out(input int idx, input bit vs, input bit pal, input bit burst,
                                   input bit act, input int uu, input int vv, input int amp);
    real th;
    int  s_t, c_t, up, vp, s, r;
    th  = 2.0 * 3.14159265358979 * real'(idx) / 256.0;
    s_t = rnd(127.0 * $sin(th));
    c_t = rnd(127.0 * $cos(th));
    up = 0; vp = 0;
    if (burst) begin
      if (pal) begin up = -((amp * 181) / 256); vp = (amp * 181) / 256; end
      else up = -amp;
    end else if (act) begin
      up = uu; vp = vv;
    end
    if (vs) vp = (vp == -128) ? 127 : -vp;
    s = up * s_t + vp * c_t;
    r = $rtoi($floor(real'(s) / 128.0));
    if (r > 255) r = 255;
    if (r < -256) r = -256;
    return r;
  endfunction

  initial begin
    int acc_m;
    bit vsw_m, vs_eff;
    int seq_u[4];
    int seq_v[4];
    int seq_vi[4];
    int seq_w[4];

    seq_u  = '{0, 126, 0, -127};
    seq_v  = '{126, 0, -127, 0};
    seq_vi = '{-127, 0, 126, 0};
    seq_w  = '{126, 123, 123, 123};

    //           idx pal ls bst act   u     v   amp  exp
    vecs[0]  = '{0,   0, 0, 0, 1,  127,    0,   0,    0};
    vecs[1]  = '{64,  0, 0, 0, 1,  127,    0,   0,  126};
    vecs[2]  = '{192, 0, 0, 0, 1,  127,    0,   0, -127};
    vecs[3]  = '{0,   0, 0, 0, 1,    0,  127,   0,  126};
    vecs[4]  = '{128, 0, 0, 0, 1,    0,  127,   0, -127};
    vecs[5]  = '{0,   1, 1, 0, 1,    0,  127,   0, -127};
    vecs[6]  = '{32,  0, 0, 0, 1, -128, -128,   0, -180};
    vecs[7]  = '{32,  0, 0, 0, 1,  127,  127,   0,  178};
    vecs[8]  = '{0,   1, 1, 0, 1,    0, -128,   0,  126};
    vecs[9]  = '{64,  0, 0, 1, 1,  100,    0,  40,  -40};
    vecs[10] = '{64,  0, 0, 0, 0,  100,    0,   0,    0};
    vecs[11] = '{0,   1, 0, 1, 0,    0,    0, 100,   69};
    vecs[12] = '{0,   1, 1, 1, 0,    0,    0, 100,  -70};
    vecs[13] = '{64,  1, 0, 1, 0,    0,    0, 100,  -70};
    vecs[14] = '{64,  0, 0, 1, 0,    0,    0, 255, -254};
    vecs[15] = '{64,  0, 0, 0, 1, -128,    0,   0, -127};
    vecs[16] = '{32,  0, 0, 0, 0,    5,    5,   0,    0};

    // Reset state.
    idle_inputs();
    rst_n = 0;
    repeat (3) step();
    check("reset_chroma", int'(chroma_out), 0);
    check("reset_vsw", int'(vsw), 0);
    rst_n = 1;

    // Run with PAL switching active, then pull reset mid-cycle.
    phase_inc = 32'h4000_0000; active = 1; u = 100; pal_mode = 1; line_start = 1;
    step();
    line_start = 0;
    repeat (4) step();
    check("pre_reset_vsw", int'(vsw), 1);
    #3 rst_n = 0;
    #1;
    check("async_reset_chroma", int'(chroma_out), 0);
    check("async_reset_vsw", int'(vsw), 0);
    pal_mode = 0; u = 127; v = 0;
    step();
    rst_n = 1;
    // Accumulator restarts at 0, so the pure-U carrier starts at idx 0.
    repeat (2) step();
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("pure_u[%0d]", i), int'(chroma_out), seq_u[i % 4]);
    end

    // Pure V after phase_clear, NTSC.
    phase_clear = 1; u = 0; v = 127;
    step();
    phase_clear = 0;
    repeat (2) step();
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("pure_v[%0d]", i), int'(chroma_out), seq_v[i % 4]);
    end

    // Same in PAL after one line_start: V inverted.
    phase_clear = 1; pal_mode = 1; line_start = 1;
    step();
    phase_clear = 0; line_start = 0;
    repeat (2) step();
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("pal_v_inv[%0d]", i), int'(chroma_out), seq_vi[i % 4]);
    end
    check("pal_vsw_set", int'(vsw), 1);
    pal_mode = 0;
    step();
    check("pal_fall_clears_vsw", int'(vsw), 0);

    // Phase wrap: decrementing accumulator passes 0 -> all-ones (idx 0 -> 255).
    phase_clear = 1; u = 127; v = 127; active = 1;
    step();
    phase_clear = 0; phase_inc = 32'hFFFF_FFFF;
    repeat (2) step();
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("wrap[%0d]", i), int'(chroma_out), seq_w[i]);
    end

    // Directed vector table.
    for (int k = 0; k < 17; k++) begin
      idle_inputs();
      set_phase(vecs[k].idx);
      pal_mode = vecs[k].pal; line_start = vecs[k].ls; burst_en = vecs[k].burst;
      active = vecs[k].act; u = 8'(vecs[k].uu); v = 8'(vecs[k].vv); burst_amp = 8'(vecs[k].amp);
      step();
      line_start = 0;
      repeat (2) step();
      $display("vec %0d: idx=%0d pal=%0d ls=%0d burst=%0d act=%0d u=%0d v=%0d amp=%0d -> chroma=%0d vsw=%0d",
               k, vecs[k].idx, vecs[k].pal, vecs[k].ls, vecs[k].burst, vecs[k].act,
               vecs[k].uu, vecs[k].vv, vecs[k].amp, chroma_out, vsw);
      check($sformatf("vec%0d_chroma", k), int'(chroma_out), vecs[k].exp_c);
      check($sformatf("vec%0d_vsw", k), int'(vsw), int'(vecs[k].pal & vecs[k].ls));
    end

    // Randomised run against the reference model.
    idle_inputs();
    phase_clear = 1;
    step();
    acc_m = 0; vsw_m = 0;
    exp_q.delete();
    for (int n = 0; n < 1500; n++) begin
      phase_inc   = $urandom;
      phase_clear = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 63) == 0) pal_mode = ~pal_mode;
      line_start  = ($urandom_range(0, 7) == 0);
      burst_en    = ($urandom_range(0, 3) == 0);
      active      = ($urandom_range(0, 1) == 1);
      u           = ($urandom_range(0, 15) == 0) ? -8'sd128 : 8'($urandom);
      v           = ($urandom_range(0, 15) == 0) ? -8'sd128 : 8'($urandom);
      burst_amp   = 8'($urandom);
      vs_eff = pal_mode & (vsw_m ^ line_start);
      exp_q.push_back(model_out((acc_m >> 24) & 255, vs_eff, pal_mode, burst_en, active,
                                int'(u), int'(v), int'(burst_amp)));
      step();
      acc_m = phase_clear ? 0 : acc_m + int'(phase_inc);
      vsw_m = vs_eff;
      check($sformatf("rand%0d_vsw", n), int'(vsw), int'(vsw_m));
      if (exp_q.size() == 3) check($sformatf("rand%0d_chroma", n), int'(chroma_out), exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
